// File: rtl/ma_filter_pkg.sv
// ma_filter_pkg: shared widths, per-lane types and helpers for the
// multi-channel moving-average filter (ma_filter_multich, ma_filter_lane).
//   - DEF_* : default geometry of the filter.
//   - sample_t / sum_t : per-lane signed sample and accumulator at default widths.
//   - sum_width() : accumulator width for a given sample width and max window.
//   - round_term() : half-LSB offset added before a shift by 'win' bits.
package ma_filter_pkg;

  localparam int DEF_NUM_CHANNELS   = 4;
  localparam int DEF_WORD_LENGTH_IN = 16;
  localparam int DEF_MAX_LOG2       = 4;

  function automatic int sum_width(input int word_length_in, input int max_log2);
    return word_length_in + max_log2;
  endfunction

  typedef logic signed [DEF_WORD_LENGTH_IN-1:0]              sample_t;
  typedef logic signed [DEF_WORD_LENGTH_IN+DEF_MAX_LOG2-1:0] sum_t;

  function automatic int unsigned round_term(input int unsigned win);
    return (win == 0) ? 32'd0 : (32'd1 << (win - 1));
  endfunction

endpackage

// File: rtl/ma_filter_lane.sv
// ma_filter_lane: one lane of the moving-average filter.
// Holds the circular sample buffer, the running sum and the scaled output
// register for a single antenna element.
// Optional macro MA_FILTER_ROUND_EN: round half-up before the shift (else floor).
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset
//   clear_i         synchronous clear of the running sum
//   acc_i           sample accepted this cycle
//   full_i          window already holds N samples (oldest sample leaves)
//   out_load_i      load the output register with the post-update mean
//   wr_ptr_i        buffer write pointer
//   win_q_i         latched window exponent
//   x_i             input sample
//   y_o             registered averaged sample
module ma_filter_lane
  import ma_filter_pkg::*;
#(
  parameter int WORD_LENGTH_IN  = DEF_WORD_LENGTH_IN,
  parameter int MAX_LOG2        = DEF_MAX_LOG2,
  parameter int WIN_W           = $clog2(MAX_LOG2 + 1),
  parameter int WORD_LENGTH_SUM = sum_width(WORD_LENGTH_IN, MAX_LOG2)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             clear_i,
  input  logic                             acc_i,
  input  logic                             full_i,
  input  logic                             out_load_i,
  input  logic        [MAX_LOG2-1:0]       wr_ptr_i,
  input  logic        [WIN_W-1:0]          win_q_i,
  input  logic signed [WORD_LENGTH_IN-1:0] x_i,
  output logic signed [WORD_LENGTH_IN-1:0] y_o
);

  localparam int DEPTH = 1 << MAX_LOG2;

  logic signed [WORD_LENGTH_IN-1:0]  buf_q [DEPTH];
  logic signed [WORD_LENGTH_SUM-1:0] sum_q, sum_d;
  logic signed [WORD_LENGTH_SUM-1:0] rnd, rounded;
  logic signed [WORD_LENGTH_IN-1:0]  x_old, y_q, y_d;
  logic        [MAX_LOG2:0]          n_val;
  logic        [MAX_LOG2-1:0]        rd_ptr;

  // Window length truncated to pointer width: N = 2^MAX_LOG2 maps to 0,
  // so the oldest sample is the slot about to be overwritten.
  assign n_val  = (MAX_LOG2 + 1)'(1) << win_q_i;
  assign rd_ptr = wr_ptr_i - n_val[MAX_LOG2-1:0];

  always_comb begin
    x_old = '0;
    if (full_i) begin
      x_old = buf_q[rd_ptr];
    end
  end

  // Intermediate sum+x may wrap, but the final sum of N in-range samples fits.
  assign sum_d = sum_q + WORD_LENGTH_SUM'(x_i) - WORD_LENGTH_SUM'(x_old);

`ifdef MA_FILTER_ROUND_EN
  assign rnd = WORD_LENGTH_SUM'(round_term(32'(win_q_i)));
`else
  assign rnd = '0;
`endif

  assign rounded = sum_d + rnd;
  assign y_d     = WORD_LENGTH_IN'(rounded >>> win_q_i);

  // Buffer contents are never reset; fill gating keeps stale slots out of the sum.
  always_ff @(posedge clk_i) begin
    if (acc_i) begin
      buf_q[wr_ptr_i] <= x_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
      y_q   <= '0;
    end else begin
      if (clear_i) begin
        sum_q <= '0;
      end else if (acc_i) begin
        sum_q <= sum_d;
      end
      if (out_load_i) begin
        y_q <= y_d;
      end
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/ma_filter_multich.sv
// ma_filter_multich: multi-channel signed moving average over 2^win_log2
// snapshots (capped at 2^MAX_LOG2), AXI-Stream in and out with backpressure.
// Optional macro MA_FILTER_ROUND_EN: round half-up instead of floor.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   win_log2          window exponent (a change triggers an internal flush)
//   flush             one-cycle synchronous clear of window state
//   s_axis_*          input snapshot stream, lane 0 in LSBs
//   m_axis_*          averaged snapshot stream
//   fill_done         window full, outputs are being produced
module ma_filter_multich
  import ma_filter_pkg::*;
#(
  parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
  parameter int WORD_LENGTH_IN  = DEF_WORD_LENGTH_IN,
  parameter int MAX_LOG2        = DEF_MAX_LOG2,
  parameter int WIN_W           = $clog2(MAX_LOG2 + 1),
  parameter int WORD_LENGTH_SUM = sum_width(WORD_LENGTH_IN, MAX_LOG2)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [WIN_W-1:0]                       win_log2,
  input  logic                                   flush,
  input  logic [NUM_CHANNELS*WORD_LENGTH_IN-1:0] s_axis_tdata,
  input  logic                                   s_axis_tvalid,
  output logic                                   s_axis_tready,
  output logic [NUM_CHANNELS*WORD_LENGTH_IN-1:0] m_axis_tdata,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic                                   fill_done
);

  localparam int CNT_W = MAX_LOG2 + 1;

  logic [WIN_W-1:0]    win_eff, win_q, win_d;
  logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d, n_val;
  logic [MAX_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic                mvalid_q, mvalid_d;
  logic                flush_int, acc, full, out_load;

  assign win_eff   = (win_log2 > WIN_W'(MAX_LOG2)) ? WIN_W'(MAX_LOG2) : win_log2;
  assign flush_int = flush | (win_eff != win_q);

  assign s_axis_tready = !flush_int & (!mvalid_q | m_axis_tready);
  assign acc           = s_axis_tvalid & s_axis_tready;

  assign n_val     = CNT_W'(1) << win_q;
  assign full      = (fill_cnt_q == n_val);
  assign fill_done = full;
  // Output is produced whenever the window is full after this accept.
  assign out_load  = acc & (full | ((fill_cnt_q + CNT_W'(1)) == n_val));

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    mvalid_d   = mvalid_q;
    win_d      = win_q;
    if (flush_int) begin
      fill_cnt_d = '0;
      wr_ptr_d   = '0;
      mvalid_d   = 1'b0;
      win_d      = win_eff;
    end else begin
      if (acc) begin
        wr_ptr_d = wr_ptr_q + MAX_LOG2'(1);
        if (!full) begin
          fill_cnt_d = fill_cnt_q + CNT_W'(1);
        end
      end
      if (out_load) begin
        mvalid_d = 1'b1;
      end else if (m_axis_tready) begin
        mvalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
      wr_ptr_q   <= '0;
      mvalid_q   <= 1'b0;
      win_q      <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      mvalid_q   <= mvalid_d;
      win_q      <= win_d;
    end
  end

  assign m_axis_tvalid = mvalid_q;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_lane
    ma_filter_lane #(
      .WORD_LENGTH_IN  (WORD_LENGTH_IN),
      .MAX_LOG2        (MAX_LOG2),
      .WIN_W           (WIN_W),
      .WORD_LENGTH_SUM (WORD_LENGTH_SUM)
    ) u_lane (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .clear_i    (flush_int),
      .acc_i      (acc),
      .full_i     (full),
      .out_load_i (out_load),
      .wr_ptr_i   (wr_ptr_q),
      .win_q_i    (win_q),
      .x_i        (s_axis_tdata[g*WORD_LENGTH_IN +: WORD_LENGTH_IN]),
      .y_o        (m_axis_tdata[g*WORD_LENGTH_IN +: WORD_LENGTH_IN])
    );
  end

endmodule

// File: tb/tb_ma_filter_multich.sv
module tb_ma_filter_multich;

  localparam int NCH = 2;
  localparam int WL  = 16;
  localparam int ML  = 4;
  localparam int WW  = $clog2(ML + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WW-1:0]     win_log2;
  logic              flush;
  logic [NCH*WL-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [NCH*WL-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              fill_done;

  int n_checks = 0;
  int n_pass   = 0;

  ma_filter_multich #(
    .NUM_CHANNELS   (NCH),
    .WORD_LENGTH_IN (WL),
    .MAX_LOG2       (ML)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .win_log2      (win_log2),
    .flush         (flush),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .fill_done     (fill_done)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] lane(input int idx);
    logic signed [WL-1:0] v;
    v = m_axis_tdata[idx*WL +: WL];
    return 32'(v);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Called just after a negedge; returns at the negedge following acceptance.
  task automatic push(input int a, input int b);
    bit ok;
    ok = 1'b0;
    s_axis_tdata  = {16'(b), 16'(a)};
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = s_axis_tready;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1;
    check("flush_tready", 32'(s_axis_tready), 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_tvalid", 32'(m_axis_tvalid), 0);
    check("flush_fill", 32'(fill_done), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    win_log2      = '0;
    flush         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    #12;
    check("rst_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_tdata", 32'(m_axis_tdata), 0);
    check("rst_fill", 32'(fill_done), 0);
    check("rst_tready", 32'(s_axis_tready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // win_log2=0: pass-through with one cycle latency
    push(123, -7);
    check("w0_valid", 32'(m_axis_tvalid), 1);
    check("w0_l0", lane(0), 123);
    check("w0_l1", lane(1), -7);
    push(-500, 42);
    check("w0_l0b", lane(0), -500);

    // Basic window of 4
    win_log2 = 3'd2;
    push(4, 0);
    push(8, 0);
    push(12, 0);
    check("basic_nvalid", 32'(m_axis_tvalid), 0);
    check("basic_nfill", 32'(fill_done), 0);
    push(16, 0);
    check("basic_valid", 32'(m_axis_tvalid), 1);
    check("basic_fill", 32'(fill_done), 1);
    check("basic_o1", lane(0), 10);
    push(20, 0);
    check("basic_o2", lane(0), 14);
    push(24, 0);
    check("basic_o3", lane(0), 18);

    // Flush drops a pending unconsumed output
    m_axis_tready = 1'b0;
    do_flush();
    m_axis_tready = 1'b1;

    // Signed / rounding
    push(1, -1);
    push(2, -1);
    push(3, -1);
    push(5, -2);
`ifdef MA_FILTER_ROUND_EN
    check("rnd_l0", lane(0), 3);
    check("rnd_l1", lane(1), -1);
`else
    check("rnd_l0", lane(0), 2);
    check("rnd_l1", lane(1), -2);
`endif

    // Backpressure: lane0 = 4k, lane1 = 4k+100
    do_flush();
    for (int k = 1; k <= 4; k++) push(4 * k, 4 * k + 100);
    check("bp_o4", lane(0), 10);
    check("bp_o4_l1", lane(1), 110);
    m_axis_tready = 1'b0;
    s_axis_tdata  = {16'(120), 16'(20)};
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_tready", 32'(s_axis_tready), 0);
      check("bp_stall_tvalid", 32'(m_axis_tvalid), 1);
      check("bp_stall_data", lane(0), 10);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      push(4 * k, 4 * k + 100);
      check("bp_valid", 32'(m_axis_tvalid), 1);
      check("bp_seq", lane(0), 4 * k - 6);
    end

    // Extremes, window of 16
    win_log2 = 3'd4;
    for (int k = 0; k < 15; k++) push(32767, 32767);
    check("ext_nfill", 32'(fill_done), 0);
    push(32767, 32767);
    check("ext_max_l0", lane(0), 32767);
    check("ext_max_l1", lane(1), 32767);
    push(-32768, -32768);
    check("ext_mix", lane(0), 28671);
    for (int k = 0; k < 15; k++) push(-32768, -32768);
    check("ext_min_l0", lane(0), -32768);
    check("ext_min_l1", lane(1), -32768);

    // Window change 4 -> 2 -> 3
    @(negedge clk);
    win_log2 = 3'd2;
    #1;
    check("wc_tready0", 32'(s_axis_tready), 0);
    @(negedge clk);
    check("wc_tvalid0", 32'(m_axis_tvalid), 0);
    for (int k = 1; k <= 6; k++) push(k, k);
    check("wc_pre_valid", 32'(m_axis_tvalid), 1);
    win_log2 = 3'd3;
    #1;
    check("wc_tready1", 32'(s_axis_tready), 0);
    @(negedge clk);
    check("wc_tvalid1", 32'(m_axis_tvalid), 0);
    check("wc_fill1", 32'(fill_done), 0);
    for (int k = 1; k <= 7; k++) push(10 * k, 10 * k);
    check("wc_nvalid", 32'(m_axis_tvalid), 0);
    push(80, 80);
    check("wc_mean", lane(0), 45);

    // win_log2=7 clamps to 4
    win_log2 = 3'd7;
    for (int k = 1; k <= 15; k++) push(2 * k, 2 * k);
    check("w7_nvalid", 32'(m_axis_tvalid), 0);
    push(32, 32);
    check("w7_valid", 32'(m_axis_tvalid), 1);
    check("w7_mean", lane(1), 17);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(m_axis_tvalid), 0);
    check("arst_tdata", 32'(m_axis_tdata), 0);
    check("arst_fill", 32'(fill_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) push(5, 5);
    check("arst_nvalid", 32'(m_axis_tvalid), 0);
    push(5, 5);
    check("arst_valid", 32'(m_axis_tvalid), 1);
    check("arst_mean", lane(0), 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
